// File: rtl/modulo_varredura_matriz_pkg.sv
// Shared constants, state encoding and bit mapping for the 5x7 matrix scan driver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package modulo_matriz_pkg;

  localparam int N_COLS = 5;
  localparam int N_ROWS = 7;
  localparam int N_BITS = 35;

  // Scan FSM encoding, kept as plain 2-bit constants so older tools and
  // waveform scripts that match on raw state values keep working.
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t DRIVE = 2'd1;
  localparam state_t GAP   = 2'd2;

  // Image bit for row r, column c: row 0 / col 0 lives in the MSB.
  function automatic logic [5:0] bit_idx(input int r, input int c);
    return 6'(N_BITS - 1 - (r * N_COLS + c));
  endfunction

endpackage

// File: rtl/modulo_varredura_matriz_prescaler.sv
// Dwell prescaler: free-running 0..DIV_MAX counter with synchronous clear and terminal-count tick.
// Latency: tick is combinational from the count register; count updates one edge after a clear.
// Backpressure: none; cnt_clr has priority over counting.
//
// Ports:
//   clk      in   system clock, rising edge
//   clr      in   asynchronous active-low reset
//   cnt_clr  in   synchronous clear (count returns to 0 on the next edge)
//   cnt      out  current count, never above DIV_MAX
//   tick     out  high while cnt == DIV_MAX
module modulo_prescaler #(
  parameter int DIV_W   = 16,
  parameter int DIV_MAX = 49999
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cnt_clr,
  output logic [DIV_W-1:0] cnt,
  output logic             tick
);

  assign tick = (cnt == DIV_W'(DIV_MAX));

  // Wrapping at the terminal count keeps cnt within 0..DIV_MAX even when the
  // owner forgets to clear it.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (cnt_clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/modulo_varredura_matriz.sv
// Column-multiplexed 5x7 LED scan driver with frame-synchronous shadow image and blanking gaps.
// Latency: all outputs registered; a new column appears on the edge that selects it.
// Backpressure: upd_req is a held level; it is acknowledged (upd_ack pulse) only in IDLE or at a frame boundary.
//
// Ports:
//   clk          in   system clock, rising edge
//   clr          in   asynchronous active-low reset
//   en           in   scan enable (level)
//   m_in         in   35-bit image, bit 34-(r*5+c) = row r, col c
//   upd_req      in   request to load m_in into the shadow image
//   upd_ack      out  one-cycle pulse on the edge the shadow was loaded
//   frame_start  out  one-cycle pulse when column 0 begins driving
//   col_n        out  active-low one-hot column select
//   row          out  active-high row data for the driven column
module modulo_varredura_matriz
  import modulo_matriz_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int DIV_MAX = 49999,
  // Blanking cycles share the dwell counter, so keep GAP_CYC <= DIV_MAX+1.
  parameter int GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [N_BITS-1:0] m_in,
  input  logic              upd_req,
  output logic              upd_ack,
  output logic              frame_start,
  output logic [N_COLS-1:0] col_n,
  output logic [N_ROWS-1:0] row
);

  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [2:0]       COL_LAST = 3'(N_COLS - 1);

  state_t            state, state_nxt;
  logic [2:0]        col, col_nxt, col_inc;
  logic [N_BITS-1:0] shadow, shadow_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic              div_tick;
  logic              cnt_clr;
  logic              drive_on;   // next cycle drives a column
  logic              boundary;   // next cycle starts column 0
  logic              load;
  logic [N_COLS-1:0] col_n_nxt;
  logic [N_ROWS-1:0] row_nxt;

  modulo_prescaler #(
    .DIV_W   (DIV_W),
    .DIV_MAX (DIV_MAX)
  ) u_prescaler (
    .clk     (clk),
    .clr     (clr),
    .cnt_clr (cnt_clr),
    .cnt     (div_cnt),
    .tick    (div_tick)
  );

  assign col_inc = (col == COL_LAST) ? 3'd0 : col + 3'd1;

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    cnt_clr   = 1'b0;
    drive_on  = 1'b0;
    boundary  = 1'b0;

    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        col_nxt = 3'd0;
        if (en) begin
          state_nxt = DRIVE;
          drive_on  = 1'b1;
          boundary  = 1'b1;
        end
      end
      DRIVE: begin
        if (!en) begin
          state_nxt = IDLE;
          col_nxt   = 3'd0;
          cnt_clr   = 1'b1;
        end else if (div_tick) begin
          cnt_clr = 1'b1;
          if (GAP_CYC == 0) begin
            col_nxt  = col_inc;
            drive_on = 1'b1;
            boundary = (col == COL_LAST);
          end else begin
            state_nxt = GAP;
          end
        end else begin
          drive_on = 1'b1;
        end
      end
      GAP: begin
        if (!en) begin
          state_nxt = IDLE;
          col_nxt   = 3'd0;
          cnt_clr   = 1'b1;
        end else if (div_cnt == GAP_LAST) begin
          state_nxt = DRIVE;
          col_nxt   = col_inc;
          cnt_clr   = 1'b1;
          drive_on  = 1'b1;
          boundary  = (col == COL_LAST);
        end
      end
      default: begin
        state_nxt = IDLE;
        col_nxt   = 3'd0;
        cnt_clr   = 1'b1;
      end
    endcase

    // IDLE always services a request; while scanning, only the frame
    // boundary does, so a frame is never drawn from two images.
    load       = upd_req && ((state == IDLE) || boundary);
    shadow_nxt = load ? m_in : shadow;

    // Rows come from the post-load image so a freshly loaded frame is
    // visible on its very first column.
    row_nxt = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      row_nxt[r] = drive_on & shadow_nxt[bit_idx(r, int'(col_nxt))];
    end
    col_n_nxt = drive_on ? ~(N_COLS'(1) << col_nxt) : '1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= IDLE;
      col         <= 3'd0;
      shadow      <= '0;
      col_n       <= '1;
      row         <= '0;
      upd_ack     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      col         <= col_nxt;
      shadow      <= shadow_nxt;
      col_n       <= col_n_nxt;
      row         <= row_nxt;
      upd_ack     <= load;
      frame_start <= boundary;
    end
  end

endmodule
